// File: rtl/contador_pontos_multicanal_if.sv
// Bus bundle for the multichannel score counter bank.
// The master drives the requests; the slave (the counter bank) drives the status.
interface contador_pontos_multicanal_if #(
    parameter int CANAIS  = 2,
    parameter int N       = 10,
    parameter int PASSO_W = 4
);
    localparam int LW = (CANAIS > 1) ? $clog2(CANAIS) : 1;

    logic [CANAIS-1:0]   inc;
    logic [CANAIS-1:0]   dec;
    logic [PASSO_W-1:0]  passo;
    logic [CANAIS-1:0]   carrega;
    logic [N-1:0]        valor;
    logic [CANAIS*N-1:0] Q;
    logic [CANAIS-1:0]   no_max;
    logic [CANAIS-1:0]   no_zero;
    logic [CANAIS-1:0]   combo_ativo;
    logic [CANAIS-1:0]   evento;
    logic [LW-1:0]       lider;

    modport master (
        output inc, dec, passo, carrega, valor,
        input  Q, no_max, no_zero, combo_ativo, evento, lider
    );

    modport slave (
        input  inc, dec, passo, carrega, valor,
        output Q, no_max, no_zero, combo_ativo, evento, lider
    );
endinterface

// File: rtl/contador_pontos_multicanal.sv
// Bank of independent up/down score counters with step doubling (combo), saturate or wrap
// modes, synchronous load, a one-cycle max/wrap event and a registered leader index.
module contador_pontos_multicanal #(
    parameter int CANAIS    = 2,
    parameter int M         = 1000,
    parameter int N         = 10,
    parameter int PASSO_W   = 4,
    parameter int COMBO_LIM = 4,
    parameter int MODO_WRAP = 0
) (
    input  logic                  clock,
    input  logic                  zera_s,
    contador_pontos_multicanal_if.slave bus
);
    localparam int LW = (CANAIS > 1) ? $clog2(CANAIS) : 1;
    localparam int W  = N + PASSO_W + 2;
    localparam int SW = (COMBO_LIM > 1) ? $clog2(COMBO_LIM + 1) : 1;
    localparam logic [W-1:0]  TOPO = W'(M - 1);
    localparam logic [W-1:0]  MODV = W'(M);
    localparam logic [SW-1:0] LIM  = SW'(COMBO_LIM);

    logic [N-1:0]      q_r        [CANAIS];
    logic [N-1:0]      q_nxt      [CANAIS];
    logic [SW-1:0]     streak_r   [CANAIS];
    logic [SW-1:0]     streak_nxt [CANAIS];
    logic [CANAIS-1:0] combo_r;
    logic [CANAIS-1:0] evento_r;
    logic [CANAIS-1:0] evento_nxt;
    logic [LW-1:0]     lider_r;
    logic [LW-1:0]     lider_nxt;

    // All arithmetic is done W bits wide so step plus count can never overflow silently.
    always_comb begin
        logic [W-1:0] atual;
        logic [W-1:0] s;
        logic [W-1:0] soma;
        atual      = '0;
        s          = '0;
        soma       = '0;
        evento_nxt = '0;
        for (int c = 0; c < CANAIS; c++) begin
            atual = W'(q_r[c]);
            s     = W'(bus.passo) << combo_r[c];
            if (s > TOPO) s = TOPO;
            soma  = atual + s;

            q_nxt[c]      = q_r[c];
            streak_nxt[c] = streak_r[c];

            if (bus.carrega[c]) begin
                q_nxt[c]      = (W'(bus.valor) > TOPO) ? N'(TOPO) : bus.valor;
                streak_nxt[c] = '0;
            end else if (bus.inc[c] && !bus.dec[c]) begin
                if (MODO_WRAP != 0) begin
                    if (soma >= MODV) begin
                        q_nxt[c]      = N'(soma - MODV);
                        evento_nxt[c] = 1'b1;
                    end else begin
                        q_nxt[c] = N'(soma);
                    end
                end else begin
                    if (soma >= TOPO) begin
                        q_nxt[c]      = N'(TOPO);
                        evento_nxt[c] = (atual < TOPO);
                    end else begin
                        q_nxt[c] = N'(soma);
                    end
                end
                if (streak_r[c] < LIM) streak_nxt[c] = streak_r[c] + 1'b1;
            end else if (bus.dec[c] && !bus.inc[c]) begin
                if (atual < s)
                    q_nxt[c] = (MODO_WRAP != 0) ? N'(atual + MODV - s) : '0;
                else
                    q_nxt[c] = N'(atual - s);
                streak_nxt[c] = '0;
            end
        end
    end

    // Leader scans the current (already updated) counts, so it trails Q by one cycle.
    always_comb begin
        logic [N-1:0] melhor;
        melhor    = q_r[0];
        lider_nxt = '0;
        for (int c = 1; c < CANAIS; c++) begin
            if (q_r[c] > melhor) begin
                melhor    = q_r[c];
                lider_nxt = LW'(c);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (zera_s) begin
            for (int c = 0; c < CANAIS; c++) begin
                q_r[c]      <= '0;
                streak_r[c] <= '0;
            end
            combo_r  <= '0;
            evento_r <= '0;
            lider_r  <= '0;
        end else begin
            for (int c = 0; c < CANAIS; c++) begin
                q_r[c]      <= q_nxt[c];
                streak_r[c] <= streak_nxt[c];
                combo_r[c]  <= (streak_nxt[c] == LIM);
            end
            evento_r <= evento_nxt;
            lider_r  <= lider_nxt;
        end
    end

    always_comb begin
        bus.Q       = '0;
        bus.no_max  = '0;
        bus.no_zero = '0;
        for (int c = 0; c < CANAIS; c++) begin
            bus.Q[c*N +: N] = q_r[c];
            bus.no_max[c]   = (q_r[c] == N'(M - 1));
            bus.no_zero[c]  = (q_r[c] == '0);
        end
    end

    assign bus.combo_ativo = combo_r;
    assign bus.evento      = evento_r;
    assign bus.lider       = lider_r;
endmodule
